// File: rtl/camera_pixel_capture_pkg.sv
// Shared types and cam_word layout for the camera pixel capture block.
// The field offsets are also consumed by the software header generator.
package camera_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_LINE_WAIT  = 3'd2,
    ST_HI_BYTE    = 3'd3,
    ST_LO_BYTE    = 3'd4
  } state_t;

  localparam int CAM_WORD_W = 26;
  localparam int PIX_W      = 16;
  localparam int SEQ_W      = 8;

  // cam_word = {frame_seq[7:0], err, valid, pixel[15:0]}
  localparam int PIX_LSB    = 0;
  localparam int VALID_BIT  = 16;
  localparam int ERR_BIT    = 17;
  localparam int SEQ_LSB    = 18;

  function automatic logic [CAM_WORD_W-1:0] pack_cam_word(
    input logic [SEQ_W-1:0] seq,
    input logic             err,
    input logic             valid,
    input logic [PIX_W-1:0] pix
  );
    logic [CAM_WORD_W-1:0] w_word;
    w_word                     = '0;
    w_word[SEQ_LSB +: SEQ_W]   = seq;
    w_word[ERR_BIT]            = err;
    w_word[VALID_BIT]          = valid;
    w_word[PIX_LSB +: PIX_W]   = pix;
    return w_word;
  endfunction

endpackage

// File: rtl/camera_pixel_capture_if.sv
// Raw OV7670-style parallel camera bus (PCLK/VSYNC/HREF/D).
interface camera_pixel_capture_if;
  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] d;

  modport master (output pclk, vsync, href, d);
  modport slave  (input  pclk, vsync, href, d);
endinterface

// File: rtl/camera_pixel_capture_sync.sv
// N-stage synchroniser bringing the camera bus into the clk domain.
// pclk, vsync, href and d travel through the same stages so a detected
// pclk rise always lines up with the d/href sampled alongside it.
module cam_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_pclk,
  input  logic       i_vsync,
  input  logic       i_href,
  input  logic [7:0] i_d,
  output logic       o_vsync,
  output logic       o_href,
  output logic [7:0] o_d,
  output logic       o_pclk_rise
);

  localparam int BUS_W = 11;

  logic [BUS_W-1:0] r_stage [SYNC_STAGES];
  logic             r_pclk_last;
  logic [BUS_W-1:0] w_synced;

  assign w_synced    = r_stage[SYNC_STAGES-1];
  assign o_vsync     = w_synced[9];
  assign o_href      = w_synced[8];
  assign o_d         = w_synced[7:0];
  assign o_pclk_rise = w_synced[10] & ~r_pclk_last;

  // Shift the raw bus through the synchroniser chain and keep one more pclk sample for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_stage[i] <= '0;
      end
      r_pclk_last <= 1'b0;
    end else begin
      r_stage[0] <= {i_pclk, i_vsync, i_href, i_d};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
      r_pclk_last <= w_synced[10];
    end
  end

endmodule

// File: rtl/camera_pixel_capture.sv
// Camera pixel capture: tracks x/y through an RGB565 frame, grabs the pixel at
// (SAMPLE_X, SAMPLE_Y) and publishes {seq, err, valid, pixel} once per frame.
module camera_pixel_capture
  import camera_pkg::*;
#(
  parameter int SAMPLE_X    = 160,
  parameter int SAMPLE_Y    = 120,
  parameter int H_MAX       = 640,
  parameter int V_MAX       = 480,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   capture_en,
  camera_pixel_capture_if.slave  cam,
  output logic [CAM_WORD_W-1:0]  cam_word,
  output logic                   frame_done
);

  localparam int XW = $clog2(H_MAX + 1);
  localparam int YW = $clog2(V_MAX + 1);

  logic                  w_vsync, w_href, w_pclk_rise;
  logic [7:0]            w_d;
  logic                  w_vsync_rise, w_vsync_fall, w_href_fall, w_byte_ok;
  logic [PIX_W-1:0]      w_pixel;

  state_t                r_state, w_state_nxt;
  logic [XW-1:0]         r_x, w_x_nxt;
  logic [YW-1:0]         r_y, w_y_nxt;
  logic [7:0]            r_hi, w_hi_nxt;
  logic [PIX_W-1:0]      r_pix, w_pix_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_hit, w_hit_nxt;
  logic [SEQ_W-1:0]      r_seq, w_seq_nxt;
  logic [CAM_WORD_W-1:0] r_word, w_word_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_vsync_prev, r_href_prev;

  cam_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_pclk      (cam.pclk),
    .i_vsync     (cam.vsync),
    .i_href      (cam.href),
    .i_d         (cam.d),
    .o_vsync     (w_vsync),
    .o_href      (w_href),
    .o_d         (w_d),
    .o_pclk_rise (w_pclk_rise)
  );

  assign w_vsync_rise = w_vsync & ~r_vsync_prev;
  assign w_vsync_fall = ~w_vsync & r_vsync_prev;
  assign w_href_fall  = ~w_href & r_href_prev;
  assign w_byte_ok    = w_pclk_rise & w_href;
  assign w_pixel      = {r_hi, w_d};

  assign cam_word     = r_word;
  assign frame_done   = r_done;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decode; href fall outranks a coincident pclk rise so that byte is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_hi_nxt    = r_hi;
    w_pix_nxt   = r_pix;
    w_err_nxt   = r_err;
    w_hit_nxt   = r_hit;
    w_seq_nxt   = r_seq;
    w_word_nxt  = r_word;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (capture_en && w_vsync) begin
          w_state_nxt = ST_WAIT_FRAME;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_FRAME: begin
        if (!capture_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_vsync_fall) begin
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_err_nxt   = 1'b0;
          w_hit_nxt   = 1'b0;
          w_state_nxt = ST_LINE_WAIT;
        end else begin
          w_state_nxt = ST_WAIT_FRAME;
        end
      end
      ST_LINE_WAIT, ST_HI_BYTE, ST_LO_BYTE: begin
        if (w_vsync_rise) begin
          w_seq_nxt  = r_seq + SEQ_W'(1);
          w_word_nxt = pack_cam_word(w_seq_nxt, r_err, r_hit, r_hit ? r_pix : {PIX_W{1'b0}});
          w_done_nxt = 1'b1;
          if (capture_en) begin
            w_state_nxt = ST_WAIT_FRAME;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (!capture_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_href_fall && (r_state != ST_LINE_WAIT)) begin
          if (r_y < YW'(V_MAX)) begin
            w_y_nxt = r_y + YW'(1);
          end else begin
            w_y_nxt = r_y;
          end
          w_err_nxt   = r_err | (r_y >= YW'(V_MAX)) | (r_state == ST_LO_BYTE);
          w_x_nxt     = '0;
          w_state_nxt = ST_LINE_WAIT;
        end else if (w_byte_ok) begin
          if (r_state == ST_LO_BYTE) begin
            if ((r_x == XW'(SAMPLE_X)) && (r_y == YW'(SAMPLE_Y))) begin
              w_pix_nxt = w_pixel;
              w_hit_nxt = 1'b1;
            end else begin
              w_pix_nxt = r_pix;
            end
            if (r_x < XW'(H_MAX)) begin
              w_x_nxt = r_x + XW'(1);
            end else begin
              w_x_nxt = r_x;
            end
            w_err_nxt   = r_err | (r_x >= XW'(H_MAX));
            w_state_nxt = ST_HI_BYTE;
          end else begin
            w_hi_nxt    = w_d;
            w_state_nxt = ST_LO_BYTE;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: counters, captured pixel, flags, output word and edge-detect history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_hi         <= 8'h00;
      r_pix        <= '0;
      r_err        <= 1'b0;
      r_hit        <= 1'b0;
      r_seq        <= '0;
      r_word       <= '0;
      r_done       <= 1'b0;
      r_vsync_prev <= 1'b0;
      r_href_prev  <= 1'b0;
    end else begin
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_hi         <= w_hi_nxt;
      r_pix        <= w_pix_nxt;
      r_err        <= w_err_nxt;
      r_hit        <= w_hit_nxt;
      r_seq        <= w_seq_nxt;
      r_word       <= w_word_nxt;
      r_done       <= w_done_nxt;
      r_vsync_prev <= w_vsync;
      r_href_prev  <= w_href;
    end
  end

endmodule

// File: tb/tb_camera_pixel_capture.sv
// Directed bench for camera_pixel_capture: drives small frames on the camera
// bus, predicts each published word into a scoreboard and compares on frame_done.
`timescale 1ns/1ps
module tb_camera_pixel_capture;

  localparam int SX = 1;
  localparam int SY = 2;
  localparam int HM = 4;
  localparam int VM = 4;
  localparam int NS = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        capture_en = 1'b0;
  logic [25:0] cam_word;
  logic        frame_done;

  camera_pixel_capture_if cam_bus();

  camera_pixel_capture #(
    .SAMPLE_X(SX), .SAMPLE_Y(SY), .H_MAX(HM), .V_MAX(VM), .SYNC_STAGES(NS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .capture_en (capture_en),
    .cam        (cam_bus.slave),
    .cam_word   (cam_word),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          m_done = 0;
  logic [7:0]  m_seq = 8'd0;
  logic [25:0] m_word = 26'd0;
  logic [25:0] sb_q[$];

  // Count every frame_done pulse seen on the falling edge.
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
  end

  // Hard stop in case the run wanders off.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_bus.d = b;
    cam_bus.href = 1'b1;
    cyc(3);
    cam_bus.pclk = 1'b1;
    cyc(3);
    cam_bus.pclk = 1'b0;
  endtask

  task automatic end_line();
    cyc(1);
    cam_bus.href = 1'b0;
    cyc(4);
  endtask

  task automatic open_frame();
    cam_bus.vsync = 1'b1;
    cyc(4);
    cam_bus.vsync = 1'b0;
    cyc(4);
  endtask

  task automatic send_lines(input int w, input int h, input int odd_line, input logic [15:0] sample);
    logic [15:0] p;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (x == SX && y == SY) p = sample;
        else p = 16'h1200 | {8'h00, 4'(x), 4'(y)};
        send_byte(p[15:8]);
        send_byte(p[7:0]);
      end
      if (y == odd_line) send_byte(8'h77);
      end_line();
    end
  endtask

  // Raise vsync and expect exactly one publish matching the scoreboard head.
  task automatic close_frame(input bit check_lat);
    bit          seen;
    int          lat;
    logic [25:0] exp;
    seen = 1'b0;
    lat = 0;
    cam_bus.vsync = 1'b1;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        lat = i;
      end
    end
    check("publish_seen", 32'(seen), 32'd1);
    exp = sb_q.pop_front();
    check("cam_word", 32'(cam_word), 32'(exp));
    if (check_lat) check("latency", 32'(lat), 32'(NS + 1));
    cyc(3);
    check("done_count", 32'(done_cnt), 32'(m_done));
  endtask

  // Raise vsync and expect nothing to be published.
  task automatic close_silent();
    cam_bus.vsync = 1'b1;
    cyc(10);
    check("no_done", 32'(done_cnt), 32'(m_done));
    check("word_held", 32'(cam_word), 32'(m_word));
  endtask

  task automatic send_frame(input int w, input int h, input int odd_line,
                            input logic [15:0] sample, input bit check_lat);
    logic e;
    logic hit;
    open_frame();
    send_lines(w, h, odd_line, sample);
    e   = (odd_line >= 0 && odd_line < h) || (w > HM) || (h > VM);
    hit = (w > SX) && (h > SY);
    m_seq  = m_seq + 8'd1;
    m_word = {m_seq, e, hit, hit ? sample : 16'h0000};
    sb_q.push_back(m_word);
    m_done++;
    close_frame(check_lat);
  endtask

  initial begin
    cam_bus.pclk  = 1'b0;
    cam_bus.vsync = 1'b0;
    cam_bus.href  = 1'b0;
    cam_bus.d     = 8'h00;
    cyc(3);
    check("reset_word", 32'(cam_word), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    capture_en = 1'b1;
    cyc(2);

    // 1: 4x4 frame with the sample pixel, plus latency and single pulse
    send_frame(4, 4, -1, 16'hBEEF, 1'b1);
    // 2: frame too small to reach the sample point
    send_frame(2, 2, -1, 16'hDEAD, 1'b0);
    // 3: odd byte count sets err, next clean frame clears it
    send_frame(3, 3, 1, 16'hCAFE, 1'b0);
    send_frame(3, 3, -1, 16'hF00D, 1'b0);
    // counter saturation limits: line too long, frame too tall, exactly at limit
    send_frame(5, 3, -1, 16'h1111, 1'b0);
    send_frame(3, 5, -1, 16'h2222, 1'b0);
    send_frame(4, 4, -1, 16'h3333, 1'b0);

    // 5: drop capture_en mid-frame, then recover
    open_frame();
    send_lines(2, 1, -1, 16'h0000);
    capture_en = 1'b0;
    cyc(4);
    close_silent();
    capture_en = 1'b1;
    cyc(4);
    send_frame(3, 3, -1, 16'h4444, 1'b0);

    // 4: 256 frames, sequence wraps, valid alternates
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) send_frame(2, 3, -1, 16'(i * 3 + 1), 1'b0);
      else            send_frame(1, 1, -1, 16'h0000, 1'b0);
      if (m_seq == 8'd0) check("seq_wrap", 32'(cam_word[25:18]), 32'd0);
    end

    // 6: async reset mid-line, then restart needs a full vsync high->low
    open_frame();
    send_byte(8'h12);
    cam_bus.d = 8'h34;
    cyc(1);
    #3;
    reset_n = 1'b0;
    #1;
    m_seq  = 8'd0;
    m_word = 26'd0;
    check("async_reset_word", 32'(cam_word), 32'd0);
    check("async_reset_done", 32'(frame_done), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cam_bus.pclk = 1'b1;
    cyc(3);
    cam_bus.pclk = 1'b0;
    send_byte(8'h56);
    send_byte(8'h78);
    end_line();
    close_silent();
    send_frame(4, 4, -1, 16'hBEEF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
